collatz_engine: RTL and testbench

Parametrised Collatz trajectory engine, next generation of the 8-bit iteration counter. Accepts a WIDTH-bit seed with a start/busy/done handshake and iterates one step per clock until the value reaches 1. Reports step count, peak value and error flags (zero seed, overflow, step limit). An optional shortcut mode fuses 3n+1 and the following halving into one step. Sits behind the top-level pin wrapper; the wrapper maps results onto uo_out/uio_out.

---
 rtl/collatz_engine.sv | 140 ++++++++++++++
 tb/tb_collatz_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/collatz_engine.sv
// Collatz trajectory engine: one step per clock from a loaded seed until the value reaches 1,
// reporting step count, peak value and zero/overflow/step-limit error flags.
module collatz_engine #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 8,
  parameter int MAX_STEPS = 255,
  parameter bit SHORTCUT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] peak,
  output logic [WIDTH-1:0] cur_n,
  output logic             err_zero,
  output logic             err_ovf,
  output logic             err_timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [WIDTH-1:0]   peak_q, peak_d;
  logic [WIDTH-1:0]   cur_n_q, cur_n_d;
  logic               err_zero_q, err_zero_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_timeout_q, err_timeout_d;

  logic [WIDTH+1:0]   t3;
  logic [WIDTH+1:0]   t_odd;
  logic               t_ovf;

  // 3n+1 needs two extra bits so an overflow can be seen rather than wrapped.
  always_comb begin
    t3    = ({2'b00, cur_n_q} << 1) + {2'b00, cur_n_q} + {{(WIDTH+1){1'b0}}, 1'b1};
    t_odd = SHORTCUT ? (t3 >> 1) : t3;
    t_ovf = |t_odd[WIDTH+1:WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    steps_d       = steps_q;
    peak_d        = peak_q;
    cur_n_d       = cur_n_q;
    err_zero_d    = err_zero_q;
    err_ovf_d     = err_ovf_q;
    err_timeout_d = err_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          steps_d       = '0;
          err_ovf_d     = 1'b0;
          err_timeout_d = 1'b0;
          busy_d        = 1'b1;
          cur_n_d       = n_in;
          peak_d        = n_in;
          if (n_in == '0) begin
            err_zero_d = 1'b1;
            state_d    = DONE;
            done_d     = 1'b1;
          end else begin
            err_zero_d = 1'b0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (cur_n_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (steps_q == CNT_W'(MAX_STEPS)) begin
          err_timeout_d = 1'b1;
          state_d       = DONE;
          done_d        = 1'b1;
        end else if (!cur_n_q[0]) begin
          cur_n_d = cur_n_q >> 1;
          steps_d = steps_q + CNT_W'(1);
        end else if (t_ovf) begin
          err_ovf_d = 1'b1;
          state_d   = DONE;
          done_d    = 1'b1;
        end else begin
          cur_n_d = t_odd[WIDTH-1:0];
          steps_d = steps_q + CNT_W'(1);
          if (t_odd[WIDTH-1:0] > peak_q) peak_d = t_odd[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      steps_q       <= '0;
      peak_q        <= '0;
      cur_n_q       <= '0;
      err_zero_q    <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      steps_q       <= steps_d;
      peak_q        <= peak_d;
      cur_n_q       <= cur_n_d;
      err_zero_q    <= err_zero_d;
      err_ovf_q     <= err_ovf_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign steps       = steps_q;
  assign peak        = peak_q;
  assign cur_n       = cur_n_q;
  assign err_zero    = err_zero_q;
  assign err_ovf     = err_ovf_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: four configurations against an arithmetic trajectory model,
// directed seeds, random seeds, mid-run reset and start-while-busy.
module tb_collatz_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [15:0] nin_v [4];
  logic [3:0]  busy_v, done_v, ez_v, eo_v, et_v;
  logic [7:0]  steps_v [4];
  logic [15:0] peak_v [4];
  logic [15:0] cur_v [4];
  logic [7:0]  peak_b, cur_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: 16-bit default, 1: 8-bit, 2: 10-step limit, 3: shortcut
  collatz_engine #(.WIDTH(16), .CNT_W(8), .MAX_STEPS(255), .SHORTCUT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .n_in(nin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .steps(steps_v[0]), .peak(peak_v[0]),
    .cur_n(cur_v[0]), .err_zero(ez_v[0]), .err_ovf(eo_v[0]), .err_timeout(et_v[0]));

  collatz_engine #(.WIDTH(8), .CNT_W(8), .MAX_STEPS(255), .SHORTCUT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .n_in(nin_v[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .steps(steps_v[1]), .peak(peak_b),
    .cur_n(cur_b), .err_zero(ez_v[1]), .err_ovf(eo_v[1]), .err_timeout(et_v[1]));

  assign peak_v[1] = {8'h00, peak_b};
  assign cur_v[1]  = {8'h00, cur_b};

  collatz_engine #(.WIDTH(16), .CNT_W(8), .MAX_STEPS(10), .SHORTCUT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .n_in(nin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .steps(steps_v[2]), .peak(peak_v[2]),
    .cur_n(cur_v[2]), .err_zero(ez_v[2]), .err_ovf(eo_v[2]), .err_timeout(et_v[2]));

  collatz_engine #(.WIDTH(16), .CNT_W(8), .MAX_STEPS(255), .SHORTCUT(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .n_in(nin_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .steps(steps_v[3]), .peak(peak_v[3]),
    .cur_n(cur_v[3]), .err_zero(ez_v[3]), .err_ovf(eo_v[3]), .err_timeout(et_v[3]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cfg_width(input int d);
    return (d == 1) ? 8 : 16;
  endfunction
  function automatic int cfg_max(input int d);
    return (d == 2) ? 10 : 255;
  endfunction

  // Walk the trajectory with plain integers; lat is the number of cycles from the
  // start edge until done is visible.
  task automatic model(input int d, input longint seed,
                       output longint st, output longint pk, output longint cn,
                       output bit ez, output bit eo, output bit et, output int lat);
    longint lim, t;
    lim = (longint'(1) << cfg_width(d)) - 1;
    st = 0; pk = seed; cn = seed; ez = 0; eo = 0; et = 0;
    if (seed == 0) begin
      ez = 1; lat = 1;
      return;
    end
    while (cn != 1) begin
      if (st == cfg_max(d)) begin et = 1; break; end
      if (cn % 2 == 0) cn = cn / 2;
      else begin
        t = 3 * cn + 1;
        if (d == 3) t = t / 2;
        if (t > lim) begin eo = 1; break; end
        cn = t;
        if (t > pk) pk = t;
      end
      st++;
    end
    lat = int'(st) + 2;
  endtask

  task automatic pulse_start(input int d, input longint seed);
    @(negedge clk);
    nin_v[d]   = 16'(seed);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
  endtask

  // Run one seed; extra_starts > 0 pokes start with another seed while busy.
  task automatic run_check(input int d, input longint seed, input int extra_starts);
    longint st, pk, cn;
    bit ez, eo, et;
    int lat, cyc;
    string tg;
    model(d, seed, st, pk, cn, ez, eo, et, lat);
    tg = $sformatf("d%0d n=%0d", d, seed);
    pulse_start(d, seed);
    cyc = 1;
    @(negedge clk);
    while (!done_v[d] && cyc < 600) begin
      if (extra_starts > 0 && cyc > 1) begin
        nin_v[d] = 16'(5);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1 start_v[d] = 1'b0;
        extra_starts--;
      end else @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tg, " latency"}, cyc, lat);
    check({tg, " busy_at_done"}, busy_v[d], 1);
    check({tg, " steps"}, steps_v[d], st);
    if (seed != 0) begin
      check({tg, " peak"}, peak_v[d], pk);
      check({tg, " cur_n"}, cur_v[d], cn);
    end else check({tg, " peak"}, peak_v[d], 0);
    check({tg, " err_zero"}, ez_v[d], ez);
    check({tg, " err_ovf"}, eo_v[d], eo);
    check({tg, " err_timeout"}, et_v[d], et);
    @(negedge clk);
    check({tg, " done_pulse_end"}, done_v[d], 0);
    check({tg, " busy_end"}, busy_v[d], 0);
    check({tg, " steps_held"}, steps_v[d], st);
  endtask

  initial begin
    int cyc;
    rst_n   = 1'b0;
    start_v = '0;
    for (int i = 0; i < 4; i++) nin_v[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst busy d%0d", i), busy_v[i], 0);
      check($sformatf("rst steps d%0d", i), steps_v[i], 0);
      check($sformatf("rst cur_n d%0d", i), cur_v[i], 0);
    end
    rst_n = 1'b1;

    run_check(0, 6, 0);
    run_check(0, 27, 0);
    run_check(0, 1, 0);
    run_check(0, 0, 0);
    run_check(1, 27, 0);
    run_check(2, 27, 0);
    run_check(3, 6, 0);
    run_check(0, 703, 0);
    run_check(0, 65535, 0);
    run_check(1, 255, 0);

    for (int i = 0; i < 12; i++) begin
      int d;
      longint s;
      d = int'($urandom_range(0, 3));
      s = (d == 1) ? longint'($urandom_range(0, 255)) : longint'($urandom_range(0, 3000));
      run_check(d, s, 0);
    end

    run_check(0, 27, 4);

    // Mid-run reset aborts cleanly without a done pulse.
    pulse_start(0, 27);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst busy", busy_v[0], 0);
    check("midrst done", done_v[0], 0);
    check("midrst steps", steps_v[0], 0);
    check("midrst peak", peak_v[0], 0);
    check("midrst cur_n", cur_v[0], 0);
    check("midrst errs", {ez_v[0], eo_v[0], et_v[0]}, 0);
    rst_n = 1'b1;
    cyc = 0;
    repeat (150) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) cyc++;
    end
    check("midrst no_done_after", cyc, 0);

    run_check(0, 7, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
